// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: sequential branch resolver.
// A branch request (PC, compare op, predicted direction) is latched in IDLE and
// held in WAIT until forwarded operands are valid. The compare result is then
// registered together with a mispredict flag and strobed for one cycle in DONE.
// Optional feature macro: BRANCH_PRED_BHT_EN. When it is defined, a per-PC table
// of 2-bit saturating counters is trained on every committed resolution and
// read combinationally by the fetch stage. When it is undefined there is no
// table and lk_taken is tied low; the port list is the same in both builds.
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PC_W-1:0]  req_pc,
  input  logic [2:0]       req_op,
  input  logic             req_pred,
  input  logic             opnd_ready,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic             flush,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  input  logic [PC_W-1:0]  lk_pc,
  output logic             lk_taken
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  // Compare op encoding shared with the control decoder.
  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_GEZ = 3'd2;
  localparam logic [2:0] OP_GTZ = 3'd3;
  localparam logic [2:0] OP_LEZ = 3'd4;
  localparam logic [2:0] OP_LTZ = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_LTU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [2:0]        op_q;
  logic              pred_q;
  logic              res_valid_q;
  logic              res_taken_q;
  logic              res_mispredict_q;

  logic              accept_s;
  logic              commit_s;
  logic              cmp_taken_s;
  logic              unused_s;

  // Zero tests use the sign bit plus an all-zero detect; lt/ltu are plain
  // WIDTH-bit signed/unsigned magnitude compares.
  function automatic logic branch_compare(input logic [2:0]       op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    logic a_zero;
    logic a_neg;
    logic r;
    a_zero = (a == {WIDTH{1'b0}});
    a_neg  = a[WIDTH-1];
    case (op)
      OP_EQ:   r = (a == b);
      OP_NE:   r = (a != b);
      OP_GEZ:  r = ~a_neg;
      OP_GTZ:  r = ~a_neg & ~a_zero;
      OP_LEZ:  r = a_neg | a_zero;
      OP_LTZ:  r = a_neg;
      OP_LT:   r = ($signed(a) < $signed(b));
      OP_LTU:  r = (a < b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cmp_taken_s = branch_compare(op_q, rd1, rd2);
  assign accept_s    = (state_q == ST_IDLE) & req_valid & ~flush;
  assign commit_s    = (state_q == ST_DONE) & ~flush;

  assign req_ready      = (state_q == ST_IDLE) & ~flush;
  assign res_valid      = res_valid_q & ~flush;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;

  // Request FSM: latch the branch, wait for operands, register the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      pc_q             <= {PC_W{1'b0}};
      op_q             <= 3'd0;
      pred_q           <= 1'b0;
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            pc_q    <= req_pc;
            op_q    <= req_op;
            pred_q  <= req_pred;
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (opnd_ready) begin
            res_taken_q      <= cmp_taken_s;
            res_mispredict_q <= cmp_taken_s ^ pred_q;
            res_valid_q      <= 1'b1;
            state_q          <= ST_DONE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BRANCH_PRED_BHT_EN
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d;
  logic [IDX_W-1:0] upd_idx_s;
  logic [IDX_W-1:0] lk_idx_s;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] counter_step(input logic [1:0] cnt,
                                              input logic       taken);
    logic [1:0] n;
    if (taken) begin
      n = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    end else begin
      n = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
    end
    return n;
  endfunction

  assign upd_idx_s = pc_q[IDX_W+1:2];
  assign lk_idx_s  = lk_pc[IDX_W+1:2];

  // Next value of the counter addressed by the branch now in DONE.
  always_comb begin
    bht_d = counter_step(bht_q[upd_idx_s], res_taken_q);
  end

  // Counter table: reset to weakly not-taken, trained on unflushed DONE exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (commit_s) begin
      bht_q[upd_idx_s] <= bht_d;
    end else begin
      bht_q[upd_idx_s] <= bht_q[upd_idx_s];
    end
  end

  // Lookup reads the stored array, so a same-cycle update is not visible yet.
  assign lk_taken = bht_q[lk_idx_s][1];
`else
  assign lk_taken = 1'b0;
`endif

  // PC bits outside the table index (or all of them without the table) are
  // intentionally unused.
  assign unused_s = ^{lk_pc, pc_q, commit_s};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a 32-bit and an 8-bit instance
// share all stimulus (the 8-bit one sees the low operand bytes) and are checked
// against an arithmetic reference model of the compare set and counter table.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_pc;
  logic [2:0]  req_op;
  logic        req_pred;
  logic        opnd_ready;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        flush;
  logic [31:0] lk_pc;
  logic [1:0]  rdy;
  logic [1:0]  vld;
  logic [1:0]  tkn;
  logic [1:0]  mis;
  logic [1:0]  lk;

  int checks   = 0;
  int failures = 0;
  int bht_m [2][64];

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(32), .PC_W(32), .BHT_DEPTH(64)) u_dut32 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_pc(req_pc), .req_op(req_op), .req_pred(req_pred),
    .opnd_ready(opnd_ready), .rd1(rd1), .rd2(rd2), .flush(flush),
    .res_valid(vld[0]), .res_taken(tkn[0]), .res_mispredict(mis[0]),
    .lk_pc(lk_pc), .lk_taken(lk[0])
  );

  branch_resolve_unit #(.WIDTH(8), .PC_W(32), .BHT_DEPTH(64)) u_dut8 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_pc(req_pc), .req_op(req_op), .req_pred(req_pred),
    .opnd_ready(opnd_ready), .rd1(rd1[7:0]), .rd2(rd2[7:0]), .flush(flush),
    .res_valid(vld[1]), .res_taken(tkn[1]), .res_mispredict(mis[1]),
    .lk_pc(lk_pc), .lk_taken(lk[1])
  );

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[w%0d] observed=%b expected=%b", tag, (k == 0) ? 32 : 8, obs, exp);
    end
  endtask

  // Reference compare: operands reduced to w bits, signed view by subtracting 2^w.
  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a_in,
                                   input logic [31:0] b_in, input int w);
    longint span, ua, ub, sa, sb;
    span = longint'(1) << w;
    ua = longint'({32'd0, a_in}) % span;
    ub = longint'({32'd0, b_in}) % span;
    sa = (ua >= span / 2) ? ua - span : ua;
    sb = (ub >= span / 2) ? ub - span : ub;
    case (op)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd2: return sa >= 0;
      3'd3: return sa > 0;
      3'd4: return sa <= 0;
      3'd5: return sa < 0;
      3'd6: return sa < sb;
      3'd7: return ua < ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic exp_lk(input int k, input logic [31:0] pc);
`ifdef BRANCH_PRED_BHT_EN
    return bht_m[k][pc_idx(pc)] >= 2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) bht_m[k][i] = 1;
  endtask

  task automatic model_train(input int k, input logic [31:0] pc, input bit t);
    int i;
    i = pc_idx(pc);
    if (t) bht_m[k][i] = (bht_m[k][i] >= 3) ? 3 : bht_m[k][i] + 1;
    else   bht_m[k][i] = (bht_m[k][i] <= 0) ? 0 : bht_m[k][i] - 1;
  endtask

  task automatic check_lookup(input string tag, input logic [31:0] pc);
    lk_pc = pc;
    #1;
    for (int k = 0; k < 2; k++) chk(tag, k, lk[k], exp_lk(k, pc));
  endtask

  // One branch: fl=0 normal, fl=1 flush in the resolving WAIT cycle, fl=2 flush in DONE.
  task automatic branch(input logic [31:0] pc, input logic [2:0] op, input logic pred,
                        input logic [31:0] a, input logic [31:0] b,
                        input int stall, input int fl);
    bit t [2];
    for (int k = 0; k < 2; k++) t[k] = ref_taken(op, a, b, (k == 0) ? 32 : 8);
    req_valid = 1'b1; req_pc = pc; req_op = op; req_pred = pred;
    opnd_ready = 1'b0; flush = 1'b0; lk_pc = pc;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("ready_idle", k, rdy[k], 1'b1);
      chk("lk_pre", k, lk[k], exp_lk(k, pc));
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_pc = $urandom; req_op = 3'($urandom); req_pred = 1'($urandom);
    for (int s = 0; s < stall; s++) begin
      opnd_ready = 1'b0; rd1 = $urandom; rd2 = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("ready_stall", k, rdy[k], 1'b0);
        chk("valid_stall", k, vld[k], 1'b0);
      end
      @(posedge clk); #1;
    end
    opnd_ready = 1'b1; rd1 = a; rd2 = b; flush = (fl == 1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("ready_wait", k, rdy[k], 1'b0);
      chk("valid_wait", k, vld[k], 1'b0);
    end
    @(posedge clk); #1;
    opnd_ready = 1'b0; rd1 = $urandom; rd2 = $urandom;
    if (fl == 1) begin
      flush = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("valid_after_wflush", k, vld[k], 1'b0);
        chk("ready_after_wflush", k, rdy[k], 1'b1);
      end
      check_lookup("lk_after_wflush", pc);
      return;
    end
    flush = (fl == 2); lk_pc = pc;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("valid_done", k, vld[k], (fl != 2));
      if (fl != 2) begin
        chk("taken", k, tkn[k], t[k]);
        chk("mispredict", k, mis[k], t[k] ^ pred);
      end
      chk("lk_same_cycle", k, lk[k], exp_lk(k, pc));
    end
    @(posedge clk); #1;
    if (fl != 2) for (int k = 0; k < 2; k++) model_train(k, pc, t[k]);
    flush = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("valid_after", k, vld[k], 1'b0);
      chk("ready_after", k, rdy[k], 1'b1);
      chk("lk_post", k, lk[k], exp_lk(k, pc));
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return $urandom;
      2: return $urandom | 32'h8000_0000;
      default: return 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, pc;
    reset = 1'b0; req_valid = 1'b0; req_pc = 32'd0; req_op = 3'd0; req_pred = 1'b0;
    opnd_ready = 1'b0; rd1 = 32'd0; rd2 = 32'd0; flush = 1'b0; lk_pc = 32'h40;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, vld[k], 1'b0);
      chk("rst_taken", k, tkn[k], 1'b0);
      chk("rst_mispredict", k, mis[k], 1'b0);
      chk("rst_ready", k, rdy[k], 1'b1);
      chk("rst_lk", k, lk[k], 1'b0);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Basic eq, stalled ltz, signed vs unsigned.
    branch(32'h10, 3'd0, 1'b0, 32'h1234, 32'h1234, 0, 0);
    branch(32'h20, 3'd5, 1'b0, 32'h8000_0000, 32'd0, 3, 0);
    branch(32'h30, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    branch(32'h30, 3'd7, 1'b1, 32'hFFFF_FFFF, 32'd1, 0, 0);
    branch(32'h34, 3'd3, 1'b1, 32'd0, 32'd0, 1, 0);
    branch(32'h38, 3'd4, 1'b0, 32'd0, 32'd0, 0, 0);
    branch(32'h3C, 3'd2, 1'b0, 32'h7FFF_FF80, 32'd0, 2, 0);

    // Saturation on pc 0x40.
    repeat (4) branch(32'h40, 3'd0, 1'b1, 32'd7, 32'd7, 0, 0);
    repeat (5) branch(32'h40, 3'd1, 1'b0, 32'd7, 32'd7, 0, 0);
    branch(32'h40, 3'd0, 1'b0, 32'd7, 32'd7, 0, 0);
    check_lookup("lk_sat", 32'h40);

    // Flushes in WAIT and DONE leave the counter untouched.
    branch(32'h50, 3'd0, 1'b0, 32'd5, 32'd5, 1, 1);
    branch(32'h50, 3'd0, 1'b0, 32'd5, 32'd5, 0, 2);
    check_lookup("lk_flushed", 32'h50);

    // Flush in IDLE blocks the accept.
    req_valid = 1'b1; req_pc = 32'h60; req_op = 3'd0; flush = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("ready_idle_flush", k, rdy[k], 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("no_accept_ready", k, rdy[k], 1'b1);
      chk("no_accept_valid", k, vld[k], 1'b0);
    end

    // Aliasing: 0x000 and 0x100 share an index.
    repeat (2) branch(32'h000, 3'd0, 1'b1, 32'd1, 32'd1, 0, 0);
    check_lookup("lk_alias", 32'h100);
    branch(32'h100, 3'd1, 1'b0, 32'd1, 32'd1, 0, 0);
    check_lookup("lk_alias_back", 32'h000);

    // Randomized branches.
    for (int n = 0; n < 300; n++) begin
      int fsel;
      a = rand_val();
      b = $urandom_range(0, 1) ? a : rand_val();
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
      fsel = $urandom_range(0, 9);
      branch(pc, 3'($urandom_range(0, 7)), 1'($urandom), a, b,
             $urandom_range(0, 3), (fsel == 0) ? 1 : ((fsel == 1) ? 2 : 0));
    end

    // Asynchronous reset in the middle of a request.
    req_valid = 1'b1; req_pc = 32'h40; req_op = 3'd0; req_pred = 1'b0; opnd_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; opnd_ready = 1'b1; rd1 = 32'd9; rd2 = 32'd9;
    reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk("midrst_valid", k, vld[k], 1'b0);
      chk("midrst_taken", k, tkn[k], 1'b0);
      chk("midrst_mispredict", k, mis[k], 1'b0);
      chk("midrst_ready", k, rdy[k], 1'b1);
    end
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    opnd_ready = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("postrst_valid", k, vld[k], 1'b0);
      chk("postrst_ready", k, rdy[k], 1'b1);
    end
    check_lookup("lk_postrst", 32'h000);
    branch(32'h44, 3'd6, 1'b1, 32'h0000_0080, 32'd1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
